// File: rtl/alarm_trigger_pkg.sv
// Shared definitions for the alarm trigger: state encoding, timer width and
// default timing parameters.
package alarm_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  localparam int unsigned TIMER_W            = 9;
  localparam int unsigned RING_SECONDS_DEF   = 60;
  localparam int unsigned SNOOZE_SECONDS_DEF = 300;
  localparam int unsigned MAX_SNOOZE_DEF     = 3;

endpackage

// File: rtl/alarm_trigger_tick_timer.sv
// Seconds counter: clears on request, counts tick pulses, and flags the tick
// that brings the count up to the limit.
module tick_timer
  import alarm_trigger_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               tick_i,
  input  logic [TIMER_W-1:0] limit_i,
  output logic               done_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (clear_i)     count_d = '0;
    else if (tick_i) count_d = count_q + TIMER_W'(1);
  end

  // Fires on the limit-th tick so the owner leaves the state before any wrap.
  assign done_o = tick_i && (count_q == limit_i - TIMER_W'(1));

endmodule

// File: rtl/alarm_trigger.sv
// Alarm clock trigger: rings on a time match, supports a bounded number of
// snoozes, and times out both the ringing and the snooze intervals.
module alarm_trigger
  import alarm_trigger_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = RING_SECONDS_DEF,
  parameter int unsigned SNOOZE_SECONDS = SNOOZE_SECONDS_DEF,
  parameter int unsigned MAX_SNOOZE     = MAX_SNOOZE_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_1hz_i,
  input  logic       enable_i,
  input  logic [7:0] cur_second_i,
  input  logic [7:0] cur_minute_i,
  input  logic [7:0] cur_hour_i,
  input  logic [7:0] alarm_minute_i,
  input  logic [7:0] alarm_hour_i,
  input  logic       stop_i,
  input  logic       snooze_i,
  output logic       ring_o,
  output logic       beep_o,
  output logic       snoozing_o,
  output logic [1:0] snooze_cnt_o
);

  localparam logic [TIMER_W-1:0] RING_LIM   = TIMER_W'(RING_SECONDS);
  localparam logic [TIMER_W-1:0] SNOOZE_LIM = TIMER_W'(SNOOZE_SECONDS);

  state_e             state_q, state_d;
  logic               ring_q, ring_d, beep_q, beep_d, snoozing_q, snoozing_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               match, kill, snooze_ok, expire, tmr_clear;
  logic [TIMER_W-1:0] tmr_limit;

  assign match = tick_1hz_i && enable_i
              && (alarm_hour_i < 8'd24) && (alarm_minute_i < 8'd60)
              && (cur_hour_i == alarm_hour_i) && (cur_minute_i == alarm_minute_i)
              && (cur_second_i == 8'd0);

  assign kill      = !enable_i || stop_i;
  assign snooze_ok = snooze_i && (32'(cnt_q) < MAX_SNOOZE);
  assign tmr_limit = (state_q == ST_SNOOZE) ? SNOOZE_LIM : RING_LIM;
  // Held at zero while idle and restarted on every state change.
  assign tmr_clear = (state_q == ST_IDLE) || (state_d != state_q);

  tick_timer u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (tmr_clear),
    .tick_i  (tick_1hz_i),
    .limit_i (tmr_limit),
    .done_o  (expire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ring_q     <= 1'b0;
      beep_q     <= 1'b0;
      snoozing_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ring_q     <= ring_d;
      beep_q     <= beep_d;
      snoozing_q <= snoozing_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (match) state_d = ST_RINGING;
      ST_RINGING: begin
        if (kill || expire) state_d = ST_IDLE;
        else if (snooze_ok) state_d = ST_SNOOZE;
      end
      ST_SNOOZE: begin
        if (kill)        state_d = ST_IDLE;
        else if (expire) state_d = ST_RINGING;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ring_d     = (state_d == ST_RINGING);
    snoozing_d = (state_d == ST_SNOOZE);
    beep_d     = 1'b0;
    if (state_d == ST_RINGING)
      beep_d = (state_q != ST_RINGING) ? 1'b1 : (beep_q ^ tick_1hz_i);
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && state_d == ST_RINGING)
      cnt_d = '0;
    else if (state_q == ST_RINGING && state_d == ST_SNOOZE)
      cnt_d = cnt_q + 2'd1;
  end

  assign ring_o       = ring_q;
  assign beep_o       = beep_q;
  assign snoozing_o   = snoozing_q;
  assign snooze_cnt_o = cnt_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Self-checking bench for alarm_trigger: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_alarm_trigger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, en, stop, snz;
  logic [7:0] cs, cm, ch, am, ah;
  logic       ring, beep, snzing;
  logic [1:0] cnt;
  logic [4:0] outv;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  alarm_trigger dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tick_1hz_i     (tick),
    .enable_i       (en),
    .cur_second_i   (cs),
    .cur_minute_i   (cm),
    .cur_hour_i     (ch),
    .alarm_minute_i (am),
    .alarm_hour_i   (ah),
    .stop_i         (stop),
    .snooze_i       (snz),
    .ring_o         (ring),
    .beep_o         (beep),
    .snoozing_o     (snzing),
    .snooze_cnt_o   (cnt)
  );

  assign outv = {ring, beep, snzing, cnt};

  // Reference model: which interval we are in, ticks elapsed in it, snoozes used.
  bit m_ring, m_snz;
  int m_el, m_cnt;

  task automatic m_reset();
    m_ring = 0; m_snz = 0; m_el = 0; m_cnt = 0;
  endtask

  task automatic m_step();
    bit hit;
    hit = tick && en && ah < 24 && am < 60 && ch == ah && cm == am && cs == 0;
    if (!m_ring && !m_snz) begin
      if (hit) begin m_ring = 1; m_el = 0; m_cnt = 0; end
    end else if (m_ring) begin
      if (!en || stop)                  m_ring = 0;
      else if (tick && m_el + 1 == 60)  m_ring = 0;
      else if (snz && m_cnt < 3) begin  m_ring = 0; m_snz = 1; m_cnt++; m_el = 0; end
      else if (tick)                    m_el++;
    end else begin
      if (!en || stop)                  m_snz = 0;
      else if (tick && m_el + 1 == 300) begin m_snz = 0; m_ring = 1; m_el = 0; end
      else if (tick)                    m_el++;
    end
  endtask

  function automatic logic [4:0] m_vec();
    return {m_ring, m_ring && (m_el % 2 == 0), m_snz, 2'(m_cnt)};
  endfunction

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b (ring,beep,snoozing,cnt)", nm, act, exp);
  endtask

  task automatic drive(input logic t, e, sp, sn, input logic [7:0] s, m, h);
    tick = t; en = e; stop = sp; snz = sn; cs = s; cm = m; ch = h;
  endtask

  task automatic step(input logic t, e, sp, sn, input logic [7:0] s, m, h, input string nm);
    drive(t, e, sp, sn, s, m, h);
    m_step();
    @(posedge clk); #1;
    chk(nm, outv, m_vec());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 8'd1, 8'd0, 8'd12, "tick");
  endtask

  task automatic fire();
    step(1, 1, 0, 0, 8'd0, 8'd30, 8'd7, "fire");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1, 0, 0, 8'd0, 8'd0, 8'd0);
    am = 8'd30; ah = 8'd7;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outv, 5'b00000);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       t, e, sp, sn;
    logic [7:0] s, m, h, am, ah;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1,1,0,0, 8'd59, 8'd29, 8'd7, 8'd30, 8'd7,  5'b00000};
    tbl[1]  = '{0,1,0,0, 8'd0,  8'd30, 8'd7, 8'd30, 8'd7,  5'b00000};
    tbl[2]  = '{1,1,0,0, 8'd0,  8'd30, 8'd7, 8'd30, 8'd7,  5'b11000};
    tbl[3]  = '{0,1,0,0, 8'd0,  8'd30, 8'd7, 8'd30, 8'd7,  5'b11000};
    tbl[4]  = '{1,1,0,0, 8'd1,  8'd30, 8'd7, 8'd30, 8'd7,  5'b10000};
    tbl[5]  = '{1,1,0,0, 8'd2,  8'd30, 8'd7, 8'd30, 8'd7,  5'b11000};
    tbl[6]  = '{0,1,0,1, 8'd2,  8'd30, 8'd7, 8'd30, 8'd7,  5'b00101};
    tbl[7]  = '{1,1,0,0, 8'd0,  8'd30, 8'd7, 8'd30, 8'd7,  5'b00101};
    tbl[8]  = '{0,1,1,0, 8'd0,  8'd30, 8'd7, 8'd30, 8'd7,  5'b00001};
    tbl[9]  = '{1,0,0,0, 8'd0,  8'd30, 8'd7, 8'd30, 8'd7,  5'b00001};
    tbl[10] = '{1,1,0,0, 8'd0,  8'd60, 8'd7, 8'd60, 8'd7,  5'b00001};
    tbl[11] = '{1,1,0,0, 8'd0,  8'd30, 8'd7, 8'd30, 8'd7,  5'b11000};
    tbl[12] = '{0,1,1,1, 8'd0,  8'd30, 8'd7, 8'd30, 8'd7,  5'b00000};
    tbl[13] = '{1,1,0,0, 8'd0,  8'd0,  8'd24, 8'd0, 8'd24, 5'b00000};
    tbl[14] = '{1,1,0,0, 8'd1,  8'd30, 8'd7, 8'd30, 8'd7,  5'b00000};

    do_reset();

    for (int i = 0; i < 15; i++) begin
      am = tbl[i].am; ah = tbl[i].ah;
      drive(tbl[i].t, tbl[i].e, tbl[i].sp, tbl[i].sn, tbl[i].s, tbl[i].m, tbl[i].h);
      m_step();
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), outv, tbl[i].exp);
    end
    am = 8'd30; ah = 8'd7;

    // Ring timeout after exactly 60 ticks.
    do_reset();
    fire();
    chk("ring_rise", outv, 5'b11000);
    ticks(59);
    chk("ring_59", outv, 5'b10000);
    ticks(1);
    chk("ring_timeout", outv, 5'b00000);

    // Snooze interval and the fourth, ignored press.
    fire();
    step(0, 1, 0, 1, 8'd5, 8'd30, 8'd7, "snz1");
    chk("snooze1", outv, 5'b00101);
    ticks(299);
    chk("snooze_299", outv, 5'b00101);
    ticks(1);
    chk("rering1", outv, 5'b11001);
    step(0, 1, 0, 1, 8'd5, 8'd30, 8'd7, "snz2");
    chk("snooze2", outv, 5'b00110);
    ticks(300);
    chk("rering2", outv, 5'b11010);
    step(0, 1, 0, 1, 8'd5, 8'd30, 8'd7, "snz3");
    chk("snooze3", outv, 5'b00111);
    ticks(300);
    chk("rering3", outv, 5'b11011);
    step(0, 1, 0, 1, 8'd5, 8'd30, 8'd7, "snz4");
    chk("snooze4_ignored", outv, 5'b11011);
    step(0, 1, 1, 1, 8'd5, 8'd30, 8'd7, "stop_snz");
    chk("stop_beats_snooze", outv, 5'b00011);

    // enable low during snooze.
    fire();
    chk("cnt_cleared", outv, 5'b11000);
    step(0, 1, 0, 1, 8'd5, 8'd30, 8'd7, "snzD");
    step(0, 0, 0, 0, 8'd5, 8'd30, 8'd7, "en_low");
    chk("en_low_snooze", outv, 5'b00001);

    // Asynchronous reset mid-ring, then a disabled match.
    fire();
    step(1, 1, 0, 0, 8'd1, 8'd30, 8'd7, "ringE");
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", outv, 5'b00000);
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 0, 0, 0, 8'd0, 8'd30, 8'd7, "dis_match");
    chk("disabled_match", outv, 5'b00000);
    ticks(3);

    // Randomized traffic against the model.
    for (int i = 0; i < 8000; i++) begin
      logic [7:0] rs, rm, rh;
      if ($urandom_range(0, 199) == 0) begin
        am = 8'($urandom_range(0, 63)); ah = 8'($urandom_range(0, 25));
      end else if ($urandom_range(0, 49) == 0) begin
        am = 8'd30; ah = 8'd7;
      end
      if ($urandom_range(0, 15) == 0) begin
        rs = 8'd0; rm = am; rh = ah;
      end else begin
        rs = 8'($urandom_range(0, 59)); rm = 8'($urandom_range(0, 59)); rh = 8'($urandom_range(0, 23));
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1499) != 0),
           1'($urandom_range(0, 1499) == 0), 1'($urandom_range(0, 19) == 0),
           rs, rm, rh, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alarm_trigger.md
ALARM_TRIGGER -- requirements
Module: alarm_trigger

Interface
REQ-001 Parameters SHALL be: RING_SECONDS, default 60, ring timeout in seconds; SNOOZE_SECONDS, default 300, snooze interval in seconds; MAX_SNOOZE, default 3, snoozes allowed per alarm event.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 tick_1hz  input  1  one-clock-wide pulse, once per second.
REQ-005 enable  input  1  alarm armed (level).
REQ-006 cur_second, cur_minute, cur_hour  input  8 each  current time, binary (0-59/0-59/0-23).
REQ-007 alarm_minute, alarm_hour  input  8 each  stored alarm time, binary.
REQ-008 stop  input  1  one-clock pulse (debounced key); ends the alarm event.
REQ-009 snooze  input  1  one-clock pulse (debounced key); requests a snooze.
REQ-010 ring  output  1  high while in RINGING.
REQ-011 beep  output  1  1 Hz buzzer pattern.
REQ-012 snoozing  output  1  high while in SNOOZE.
REQ-013 snooze_cnt  output  2  snoozes used in the current event.

Function
REQ-014 match SHALL be: tick_1hz && enable && cur_hour==alarm_hour && cur_minute==alarm_minute && cur_second==0; out-of-range alarm values never match.
REQ-015 FSM states SHALL be IDLE, RINGING and SNOOZE.
REQ-016 IDLE->RINGING on match; ring SHALL rise on the clock edge after the match cycle; snooze_cnt cleared to 0 on this transition.
REQ-017 RINGING->IDLE on stop, on enable low, or when the timer reaches RING_SECONDS ticks.
REQ-018 RINGING->SNOOZE on snooze when snooze_cnt<MAX_SNOOZE; snooze_cnt increments by 1 on that transition.
REQ-019 snooze with snooze_cnt==MAX_SNOOZE SHALL be ignored (remain RINGING).
REQ-020 SNOOZE->RINGING when the timer reaches SNOOZE_SECONDS ticks; SNOOZE->IDLE on stop or enable low.
REQ-021 Priority in any one cycle: enable low = stop > timeout/expiry > snooze.
REQ-022 match in RINGING or SNOOZE SHALL be ignored.
REQ-023 Timer: 9-bit seconds counter; cleared on every state entry; increments on tick_1hz only; never wraps (transition occurs first).
REQ-024 beep SHALL be 1 on RINGING entry, toggle on each tick_1hz while RINGING, and be 0 in IDLE and SNOOZE.
REQ-025 ring, beep, snoozing and snooze_cnt SHALL be registered outputs.
REQ-026 snooze_cnt SHALL hold its value in IDLE until the next match.

Reset
REQ-027 reset low SHALL force IDLE immediately; timer=0, ring=0, beep=0, snoozing=0, snooze_cnt=0.
REQ-028 reset asserted mid-RINGING or mid-SNOOZE SHALL silence outputs without waiting for clock; after release, the block waits for a fresh match.

Structure
REQ-029 A shared package SHALL hold the state encoding and the default values of RING_SECONDS, SNOOZE_SECONDS and MAX_SNOOZE.
REQ-030 One sub-module, tick_timer (clear, tick, 9-bit count, terminal compare against a limit), SHALL implement the timer.

Verification
REQ-031 Alarm 07:30, enable=1, time 07:30:00 with tick -> ring=1 and beep=1 next cycle; beep toggles each later tick.
REQ-032 Ringing, no keys -> ring=0 exactly 60 ticks after entry; state IDLE.
REQ-033 Ringing, snooze pulse -> snoozing=1, ring=0, snooze_cnt=1; after 300 ticks ring=1 again.
REQ-034 Four snooze presses across re-rings -> fourth press ignored, snooze_cnt stays 3, ring stays 1.
REQ-035 stop and snooze in the same cycle while ringing -> IDLE, snoozing=0; enable=0 during SNOOZE -> IDLE.
REQ-036 reset low mid-RINGING -> all outputs 0 asynchronously; match at 07:30:00 while enable=0 -> no ring.
